instr_sequencer: RTL and testbench

// - Issues the 20-bit instruction stream consumed by simple_cpu's `instruction` input. It is the producer end of that port.
// - Holds a small loadable program RAM, a program counter and a run FSM.
// - Presents one registered instruction per slot. Each slot lasts HOLD_CYCLES clocks so the CPU's multi-cycle execute completes.
// - Drives NOP_WORD whenever it is not issuing.

---
 rtl/instr_sequencer.sv | 174 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program RAM, PC and run FSM issuing held instruction slots to the CPU
// Optional feature: define SEQ_LOOP_EN to let loop_en wrap the program back to address 0.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PROG_ABITS  = 4,
  parameter int                     HOLD_CYCLES = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PROG_ABITS-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [PROG_ABITS:0]    prog_len,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PROG_ABITS-1:0]  pc,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam int              LW        = PROG_ABITS + 1;

  logic [INSTR_WIDTH-1:0] mem [2**PROG_ABITS];

  logic [1:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [PROG_ABITS-1:0]  pc_q, pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [LW-1:0]          len_q, len_d;

  logic                   ram_we;
  logic [INSTR_WIDTH-1:0] word0;
  logic [PROG_ABITS-1:0]  pc_next;
  logic                   last_slot;
  logic                   last_instr;
  logic                   wrap;

  // RAM writes are only accepted while idle; a same-cycle write to address 0 is forwarded to the first slot.
  assign ram_we     = (state_q == ST_IDLE) && load_en;
  assign word0      = (ram_we && (load_addr == '0)) ? load_data : mem[0];
  assign pc_next    = pc_q + PROG_ABITS'(1);
  assign last_slot  = (hold_q == HOLD_LAST);
  assign last_instr = ({1'b0, pc_q} == (len_q - LW'(1)));

`ifdef SEQ_LOOP_EN
  assign wrap = loop_en;
`else
  logic unused_loop_en;
  assign unused_loop_en = loop_en;
  assign wrap           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    len_d   = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            len_d   = prog_len;
            pc_d    = '0;
            instr_d = word0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            hold_d  = '0;
          end
        end
      end

      ST_ISSUE: begin
        if (stop) begin
          state_d = ST_IDLE;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          pc_d    = '0;
          hold_d  = '0;
        end else if (last_slot) begin
          hold_d = '0;
          if (last_instr) begin
            if (wrap) begin
              pc_d    = '0;
              instr_d = mem[0];
            end else begin
              state_d = ST_DONE;
              instr_d = NOP_WORD;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pc_d    = '0;
            end
          end else begin
            pc_d    = pc_next;
            instr_d = mem[pc_next];
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        pc_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
// Honours SEQ_LOOP_EN when the design is built with it.
module tb_instr_sequencer;

  localparam int          IW   = 20;
  localparam int          AB   = 4;
  localparam int          HOLD = 2;
  localparam logic [19:0] NOP  = 20'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AB:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [AB-1:0] pc;
  logic          busy;
  logic          done;

  instr_sequencer #(
    .INSTR_WIDTH(IW), .PROG_ABITS(AB), .HOLD_CYCLES(HOLD), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stop(stop), .loop_en(loop_en),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            run_s = 0;
  logic [IW-1:0] shadow [16];
  logic [23:0]   sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every issued slot must match the next scoreboard entry {pc, word}.
  always @(negedge clk) begin
    if (instr_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue: got pc=%0h instr=%0h expected no issue", pc, instruction);
      end else begin
        chk("issue_slot", {8'h0, pc, instruction}, {8'h0, sb.pop_front()});
      end
    end else begin
      chk("idle_nop", {12'h0, instruction}, {12'h0, NOP});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    load_en = 1'b1; load_addr = 4'(a); load_data = d;
    tick();
    load_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic start_run(input int len, input bit ld, input logic [AB-1:0] la,
                           input logic [IW-1:0] ld_d, input bit lp);
    if (ld) shadow[la] = ld_d;
    for (int i = 0; i < len; i++)
      for (int h = 0; h < HOLD; h++) sb.push_back({4'(i), shadow[i]});
    prog_len = 5'(len); start = 1'b1; loop_en = lp;
    load_en = ld; load_addr = la; load_data = ld_d;
    run_s = cyc;
    tick();
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic wait_done(input int exp, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) chk({name, "_done_latency"}, cyc - run_s, exp);
    tick();
    chk({name, "_done_width"}, 32'(done), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  task automatic no_done(input int n, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, "_no_done"}, 32'(seen), 32'd0);
    tick();
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_instr"}, {12'h0, instruction}, {12'h0, NOP});
    chk({name, "_valid"}, 32'(instr_valid), 32'd0);
    chk({name, "_pc"},    32'(pc), 32'd0);
    chk({name, "_busy"},  32'(busy), 32'd0);
    chk({name, "_done"},  32'(done), 32'd0);
  endtask

  typedef struct {
    int len;
    bit lp;
    int exp_done;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{3, 1'b0, 7};
    vt[1] = '{0, 1'b0, 1};
    vt[2] = '{1, 1'b0, 3};
    vt[3] = '{2, 1'b0, 5};
    vt[4] = '{16, 1'b0, 33};
`ifdef SEQ_LOOP_EN
    vt[5] = '{3, 1'b0, 7};
`else
    vt[5] = '{2, 1'b1, 5};
`endif

    tick(); tick();
    chk_idle("reset");
    rst = 1'b1;
    tick();

    load(0, 20'h1_0001);
    load(1, 20'h2_0002);
    load(2, 20'h3_0003);
    for (int i = 3; i < 16; i++) load(i, 20'($urandom));

    for (int i = 0; i < 6; i++) begin
      start_run(vt[i].len, 1'b0, '0, '0, vt[i].lp);
      wait_done(vt[i].exp_done, "table");
      loop_en = 1'b0;
    end

    // Load attempted mid-run must be dropped; the rerun still sees the old word at pc=1.
    start_run(3, 1'b0, '0, '0, 1'b0);
    tick();
    load_en = 1'b1; load_addr = 4'd1; load_data = 20'hF_FFFF;
    tick();
    load_en = 1'b0;
    wait_done(7, "busy_load");
    start_run(3, 1'b0, '0, '0, 1'b0);
    wait_done(7, "rerun");

    start_run(3, 1'b1, 4'd0, 20'hA_BCDE, 1'b0);
    wait_done(7, "load_start");

    start_run(3, 1'b0, '0, '0, 1'b0);
    tick(); tick();
    chk("stop_pre_pc", 32'(pc), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("stop");
    chk("stop_issued", sb.size(), 32'd3);
    sb.delete();
    no_done(10, "stop");
    start_run(3, 1'b0, '0, '0, 1'b0);
    wait_done(7, "after_stop");

    start_run(1, 1'b0, '0, '0, 1'b0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("stop_last");
    no_done(5, "stop_last");

    start_run(3, 1'b0, '0, '0, 1'b0);
    tick(); tick(); tick(); tick();
    chk("rst_pre_pc", 32'(pc), 32'd2);
    rst = 1'b0;
    #2;
    chk_idle("async_rst");
    sb.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
    start_run(3, 1'b0, '0, '0, 1'b0);
    wait_done(7, "after_rst");

`ifdef SEQ_LOOP_EN
    start_run(2, 1'b0, '0, '0, 1'b1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 2; i++)
        for (int h = 0; h < HOLD; h++) sb.push_back({4'(i), shadow[i]});
    for (int k = 0; k < 9; k++) tick();
    loop_en = 1'b0;
    wait_done(13, "loop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
